paddle_ctrl: RTL and testbench

Parametrised paddle controller for the Pong VGA datapath. It holds the paddle's vertical position as state and moves it once per frame from up/down buttons, ramping speed while a button is held and clamping at the screen edges. It emits a registered per-pixel `draw_paddle` for the pixel mux, replacing the fixed-height, externally positioned combinational paddle test.

---
 rtl/paddle_ctrl.sv | 117 +++++++++++
 tb/tb_paddle_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// Paddle controller: button-driven vertical position with per-frame speed ramp,
// edge clamping and a registered per-pixel hit test for the pixel mux.
module paddle_ctrl #(
    parameter int unsigned V_RES        = 480,
    parameter int unsigned PAD_HEIGHT   = 100,
    parameter int unsigned PAD_WIDTH    = 10,
    parameter int unsigned PAD_X        = 20,
    parameter int unsigned INIT_TOP     = (V_RES - PAD_HEIGHT) / 2,
    parameter int unsigned SPEED_MAX    = 8,
    parameter int unsigned ACCEL_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    output logic [9:0] pad_top,
    output logic       at_limit,
    output logic       draw_paddle
);

    localparam int unsigned MAX_TOP = V_RES - PAD_HEIGHT;
    localparam int unsigned SPD_W   = 4;
    localparam int unsigned CNT_W   = $clog2(ACCEL_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    state_t           state;
    dir_t             dir;
    logic             up_m, up_s, dn_m, dn_s;
    logic [SPD_W-1:0] speed;
    logic [SPD_W-1:0] step;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic             same_dir;
    logic [10:0]      top_ext, step_ext, dn_sum;
    logic [9:0]       up_pos, dn_pos, next_top;
    logic             hit;

    // Both or neither button pressed cancels the request.
    always_comb begin
        dir = DIR_NONE;
        if (up_s && !dn_s) begin
            dir = DIR_UP;
        end else if (dn_s && !up_s) begin
            dir = DIR_DN;
        end
    end

    // Next position: a fresh direction always moves exactly one line.
    always_comb begin
        same_dir = ((dir == DIR_UP) && (state == MOVE_UP)) ||
                   ((dir == DIR_DN) && (state == MOVE_DN));
        step     = same_dir ? speed : SPD_W'(1);
        top_ext  = {1'b0, pad_top};
        step_ext = 11'(step);
        dn_sum   = top_ext + step_ext;
        up_pos   = (top_ext < step_ext) ? 10'd0 : 10'(top_ext - step_ext);
        dn_pos   = (dn_sum > 11'(MAX_TOP)) ? 10'(MAX_TOP) : dn_sum[9:0];
        next_top = (dir == DIR_UP) ? up_pos : dn_pos;
        hold_nxt = hold_cnt + CNT_W'(1);
    end

    always_comb begin
        hit = ({1'b0, sy} >= top_ext) &&
              ({1'b0, sy} <  top_ext + 11'(PAD_HEIGHT)) &&
              ({1'b0, sx} >= 11'(PAD_X)) &&
              ({1'b0, sx} <  11'(PAD_X + PAD_WIDTH));
    end

    assign at_limit = (pad_top == 10'd0) || (pad_top == 10'(MAX_TOP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_m        <= 1'b0;
            up_s        <= 1'b0;
            dn_m        <= 1'b0;
            dn_s        <= 1'b0;
            state       <= IDLE;
            speed       <= SPD_W'(1);
            hold_cnt    <= '0;
            pad_top     <= 10'(INIT_TOP);
            draw_paddle <= 1'b0;
        end else begin
            up_m        <= btn_up;
            up_s        <= up_m;
            dn_m        <= btn_dn;
            dn_s        <= dn_m;
            draw_paddle <= hit;
            if (frame_tick) begin
                if (dir == DIR_NONE) begin
                    state    <= IDLE;
                    speed    <= SPD_W'(1);
                    hold_cnt <= '0;
                end else if (same_dir) begin
                    pad_top <= next_top;
                    if (hold_nxt == CNT_W'(ACCEL_FRAMES)) begin
                        hold_cnt <= '0;
                        speed    <= (speed < SPD_W'(SPEED_MAX)) ? speed + SPD_W'(1)
                                                                 : SPD_W'(SPEED_MAX);
                    end else begin
                        hold_cnt <= hold_nxt;
                    end
                end else begin
                    state    <= (dir == DIR_UP) ? MOVE_UP : MOVE_DN;
                    speed    <= SPD_W'(1);
                    hold_cnt <= '0;
                    pad_top  <= next_top;
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: reset, hit test, ramp, clamps, reversal, async reset.
module tb_paddle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [9:0] sx = '0;
    logic [9:0] sy = '0;
    logic [9:0] pad_top;
    logic       at_limit;
    logic       draw_paddle;

    int total = 0;
    int bad   = 0;

    // Expected positions for ticks 2..38 of a held-down ramp entered at 206.
    int exp_ramp [37] = '{208, 209, 210, 211, 213, 215, 217, 219, 222, 225, 228, 231,
                          235, 239, 243, 247, 252, 257, 262, 267, 273, 279, 285, 291,
                          298, 305, 312, 319, 327, 335, 343, 351, 359, 367, 375, 380, 380};
    int exp_accel [10] = '{191, 192, 193, 194, 195, 197, 199, 201, 203, 206};
    int exp_rev   [7]  = '{379, 378, 377, 376, 375, 373, 371};

    paddle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .sx         (sx),
        .sy         (sy),
        .pad_top    (pad_top),
        .at_limit   (at_limit),
        .draw_paddle(draw_paddle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic tick_check(input string tag, input int exp);
        tick();
        check(tag, 32'(pad_top), 32'(exp));
    endtask

    // Change buttons and let them settle through the synchroniser.
    task automatic buttons(input logic u, input logic d);
        @(negedge clk);
        btn_up = u;
        btn_dn = d;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset with toggling inputs
        repeat (6) begin
            @(negedge clk);
            btn_up     = ~btn_up;
            btn_dn     = ~btn_dn;
            frame_tick = ~frame_tick;
            sx         = sx + 10'd23;
            sy         = sy + 10'd37;
        end
        @(negedge clk);
        btn_up = 1'b0; btn_dn = 1'b0; frame_tick = 1'b0; sx = '0; sy = '0;
        rst_n  = 1'b1;
        @(negedge clk);
        check("rst_top", 32'(pad_top), 32'd190);
        check("rst_draw", 32'(draw_paddle), 32'd0);
        check("rst_limit", 32'(at_limit), 32'd0);
        for (int i = 0; i < 10; i++) tick_check("idle_hold", 190);

        // Hit test, including the one-cycle output latency
        sx = 10'd25;
        @(negedge clk); sy = 10'd0;
        @(negedge clk); sy = 10'd200;
        #1 check("hit_latency0", 32'(draw_paddle), 32'd0);
        @(negedge clk);
        check("hit_latency1", 32'(draw_paddle), 32'd1);
        for (int i = 0; i < 480; i++) begin
            @(negedge clk); sy = 10'(i);
            @(negedge clk);
            check("hit_x25", 32'(draw_paddle), 32'((i >= 190) && (i < 290)));
        end
        for (int k = 0; k < 2; k++) begin
            sx = (k == 0) ? 10'd19 : 10'd30;
            for (int i = 0; i < 480; i++) begin
                @(negedge clk); sy = 10'(i);
                @(negedge clk);
                check("hit_xedge", 32'(draw_paddle), 32'd0);
            end
        end
        sx = '0; sy = '0;

        // Acceleration from 190, then release for one tick and restart
        buttons(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick_check("accel", exp_accel[i]);
        buttons(1'b0, 1'b0);
        tick_check("release_hold", 206);
        buttons(1'b0, 1'b1);
        tick_check("restart_step1", 207);
        for (int i = 0; i < 37; i++) tick_check("ramp_dn", exp_ramp[i]);
        check("dn_limit", 32'(at_limit), 32'd1);

        // Both held, then reversal mid-ramp
        buttons(1'b1, 1'b1);
        tick_check("both_hold", 380);
        buttons(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick_check("up_ramp", exp_rev[i]);
        buttons(1'b1, 1'b1);
        tick_check("both_hold2", 371);
        buttons(1'b1, 1'b0);
        tick_check("after_both", 370);
        tick_check("up2", 369);
        tick_check("up3", 368);
        tick_check("up4", 367);
        tick_check("up5", 366);
        tick_check("up6", 364);
        buttons(1'b0, 1'b1);
        tick_check("reverse_1", 365);

        // Up clamp: run to 0, then approach from 32 so a speed-4 step hits 3
        buttons(1'b1, 1'b0);
        repeat (70) tick();
        check("up_clamp_top", 32'(pad_top), 32'd0);
        check("up_clamp_limit", 32'(at_limit), 32'd1);
        buttons(1'b0, 1'b1);
        repeat (14) tick();
        check("dn_from0", 32'(pad_top), 32'd29);
        check("mid_limit", 32'(at_limit), 32'd0);
        buttons(1'b0, 1'b0);
        tick_check("pause", 29);
        buttons(1'b0, 1'b1);
        tick_check("slow1", 30);
        tick_check("slow2", 31);
        tick_check("slow3", 32);
        buttons(1'b1, 1'b0);
        repeat (12) tick();
        tick_check("near_top7", 7);
        tick_check("near_top3", 3);
        tick_check("clamp_nowrap", 0);
        check("clamp_limit", 32'(at_limit), 32'd1);
        tick_check("clamp_hold", 0);

        // Async reset between ticks, mid-ramp
        buttons(1'b0, 1'b1);
        repeat (8) tick();
        check("pre_reset", 32'(pad_top), 32'd11);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_top", 32'(pad_top), 32'd190);
        check("async_limit", 32'(at_limit), 32'd0);
        check("async_draw", 32'(draw_paddle), 32'd0);
        buttons(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_check("post_reset_hold", 190);
        buttons(1'b0, 1'b1);
        tick_check("post_reset_s1", 191);
        tick_check("post_reset_s2", 192);
        tick_check("post_reset_s3", 193);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
